// File: rtl/serial_adder_pkg.sv
// Shared types and sizing constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int WIDTH_DEFAULT = 15;
  localparam int WIDTH_MAX     = 32;
  localparam int CNT_W         = $clog2(WIDTH_MAX);

endpackage

// File: rtl/fa_cell.sv
// Single combinational full-adder cell shared by every bit of a serial add.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_15.sv
// Bit-serial adder: one fa_cell, registered carry, LSB-first shift, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_15
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  state_t           st, stNext;
  logic [WIDTH-1:0] aSh, bSh, sumSh;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             cellS, cellCo;
  logic             lastBit;

  fa_cell uCell (
    .a  (aSh[0]),
    .b  (bSh[0]),
    .ci (carry),
    .s  (cellS),
    .co (cellCo)
  );

  assign lastBit   = (st == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign in_ready  = (st == IDLE) && rst_n;
  assign out_valid = (st == DONE);
  assign sum       = sumSh;
  assign cout      = carry;

  always_ff @(posedge clk) begin
    if (!rst_n) st <= IDLE;
    else        st <= stNext;
  end

  always_comb begin
    stNext = st;
    case (st)
      IDLE:    if (in_valid) stNext = RUN;
      RUN:     if (lastBit)  stNext = DONE;
      DONE:    if (out_ready) stNext = IDLE;
      default: stNext = IDLE;
    endcase
  end

  // Carry register doubles as cout once the last bit has been processed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aSh   <= '0;
      bSh   <= '0;
      sumSh <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          aSh   <= a;
          bSh   <= b;
          sumSh <= '0;
          cnt   <= '0;
          carry <= cin;
        end
        RUN: begin
          sumSh <= {cellS, sumSh[WIDTH-1:1]};
          aSh   <= aSh >> 1;
          bSh   <= bSh >> 1;
          carry <= cellCo;
          cnt   <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovfR;
  // On the final bit the carry register holds the carry into the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n)                        ovfR <= 1'b0;
    else if (st == IDLE && in_valid)   ovfR <= 1'b0;
    else if (lastBit)                  ovfR <= carry ^ cellCo;
  end
  assign ovf = ovfR;
`endif

endmodule

// File: tb/tb_serial_adder_15.sv
// Directed self-checking bench for serial_adder_15 (WIDTH=15).
module tb_serial_adder_15;

  localparam int W = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder_15 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accepting edge; ok=0 if in_ready never rose.
  task automatic doAccept(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic c, output bit ok);
    a = av; b = bv; cin = c; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Edges until out_valid, bounded at 100.
  task automatic waitDone(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got v=%b s=%h c=%b exp v=0 s=0000 c=0", out_valid, sum, cout); end
`ifdef SERIAL_ADDER_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
    rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_zero();
    bit ok; int n;
    doAccept(15'h0000, 15'h0000, 1'b0, ok);
    waitDone(n);
    total++; if (!ok || n != W) begin bad++; $display("FAIL zero_latency got=%0d exp=%0d ok=%b", n, W, ok); end
    total++; if (sum !== 15'h0000 || cout !== 1'b0) begin
      bad++; $display("FAIL zero_result got s=%h c=%b exp s=0000 c=0", sum, cout); end
`ifdef SERIAL_ADDER_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL zero_ovf got=%b exp=0", ovf); end
`endif
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok; int n;
    doAccept(15'h7FFF, 15'h0001, 1'b0, ok);
    waitDone(n);
    total++; if (n >= 100 || sum !== 15'h0000 || cout !== 1'b1) begin
      bad++; $display("FAIL wrap_result got s=%h c=%b n=%0d exp s=0000 c=1", sum, cout, n); end
`ifdef SERIAL_ADDER_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b exp=0", ovf); end
`endif
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  // in_valid stays high and operands change during RUN; neither may be captured.
  task automatic test_hold_valid();
    int n; int busyErr;
    a = 15'h1234; b = 15'h0F0F; cin = 1'b1; in_valid = 1'b1;
    tick();
    a = 15'h7FFF; b = 15'h7FFF; cin = 1'b0;
    busyErr = 0; n = 0;
    while (!out_valid && n < 100) begin
      if (in_ready !== 1'b0) busyErr++;
      tick(); n++;
    end
    total++; if (busyErr != 0) begin bad++; $display("FAIL hold_in_ready got=%0d high cycles exp=0", busyErr); end
    total++; if (n != W || sum !== 15'h2144 || cout !== 1'b0) begin
      bad++; $display("FAIL hold_result got s=%h c=%b n=%0d exp s=2144 c=0 n=%0d", sum, cout, n, W); end
    in_valid = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_ovf();
    bit ok; int n;
    doAccept(15'h3FFF, 15'h0001, 1'b0, ok);
    waitDone(n);
    total++; if (n >= 100 || sum !== 15'h4000 || cout !== 1'b0) begin
      bad++; $display("FAIL ovf_result got s=%h c=%b exp s=4000 c=0", sum, cout); end
`ifdef SERIAL_ADDER_OVF_EN
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
`endif
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok; int n; int errs;
    doAccept(15'h0100, 15'h0011, 1'b0, ok);
    waitDone(n);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || sum !== 15'h0111 || cout !== 1'b0 || in_ready !== 1'b0) errs++;
      tick();
    end
    total++; if (n >= 100 || errs != 0) begin
      bad++; $display("FAIL bp_stable got errs=%0d s=%h v=%b r=%b exp errs=0 s=0111", errs, sum, out_valid, in_ready); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got r=%b v=%b exp r=1 v=0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid();
    bit ok; int n;
    doAccept(15'h5555, 15'h2AAA, 1'b1, ok);
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs got v=%b s=%h r=%b exp v=0 s=0000 r=0", out_valid, sum, in_ready); end
    rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_ready got r=%b v=%b exp r=1 v=0", in_ready, out_valid); end
    doAccept(15'h0001, 15'h0001, 1'b0, ok);
    waitDone(n);
    total++; if (n != W || sum !== 15'h0002 || cout !== 1'b0) begin
      bad++; $display("FAIL midrst_new got s=%h c=%b n=%0d exp s=0002 c=0", sum, cout, n); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  // out_ready held high: DONE lasts one cycle, accept-to-accept is W+2.
  task automatic test_back_to_back();
    bit ok; int n;
    out_ready = 1'b1;
    doAccept(15'h0003, 15'h0004, 1'b0, ok);
    waitDone(n);
    total++; if (n != W || sum !== 15'h0007) begin
      bad++; $display("FAIL b2b_first got s=%h n=%0d exp s=0007 n=%0d", sum, n, W); end
    tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_done_len got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
    doAccept(15'h7FFE, 15'h0003, 1'b0, ok);
    waitDone(n);
    total++; if (n != W || sum !== 15'h0001 || cout !== 1'b1) begin
      bad++; $display("FAIL b2b_second got s=%h c=%b n=%0d exp s=0001 c=1", sum, cout, n); end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_wrap();
    test_hold_valid();
    test_ovf();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
